ps2_keymap_decoder: RTL and testbench
=====================================

// Module: ps2_keymap_decoder
// PURPOSE
//  Parametrised PS/2 scan-code decoder for N players. Consumes bytes from the PS/2 receiver
//  and parses set-2 make/break/extended (E0) sequences. Tracks held keys per player and emits
//  move pulses with hold-to-repeat, bomb pulses and a game-start pulse to the game logic.
//  Handles simultaneous keys, typematic make codes and dropped prefixes.
// PARAMETERS
//  N_PLAYERS      2                      number of players (1..4)
//  KEYMAP         {P1..}                 N_PLAYERS*5*9 bits; entry p*5+a = {ext,code}; a: 0 UP,1 DOWN,2 LEFT,3 RIGHT,4 BOMB
//                                        default P0 = 1D,1B,1C,23,29 (W S A D Space); P1 = 175,172,16B,174,05A (arrows, Enter)
//  REPEAT_CYCLES  2_500_000              move repeat period while a direction is held (>=2)
//  PREFIX_TIMEOUT 50_000                 cycles after a prefix byte before parser drops it back to IDLE
// PORTS
//  clk            in   1          system clock
//  rst            in   1          synchronous, active-high reset
//  rx_data        in   8          byte from PS/2 receiver, valid with rx_done_tick
//  rx_done_tick   in   1          one-cycle byte strobe
//  enable         in   1          1 = emit move/bomb pulses; 0 = track held keys only
//  move_valid     out  N_PLAYERS  per-player one-cycle move pulse
//  direction      out  3*N_PLAYERS per-player current direction: 0 UP,1 DOWN,2 LEFT,3 RIGHT,4 STOP
//  bomb           out  N_PLAYERS  per-player one-cycle bomb pulse
//  held           out  5*N_PLAYERS per-player held-action bitmap, bit a = action a
//  start          out  1          one-cycle pulse on first mapped make after reset
// BEHAVIOUR
//  Reset (sync): parser IDLE; move_valid=0, bomb=0, start=0, held=0, direction=4 for all players.
//  Reset also clears repeat counters, the timeout counter and the start-seen flag; mid-sequence bytes are dropped.
//  Parser states: IDLE, EXT, BRK, EXT_BRK; all transitions happen on rx_done_tick only.
//   IDLE: E0->EXT; F0->BRK; other byte b -> make{0,b}.
//   EXT: F0->EXT_BRK; E0->EXT; b -> make{1,b}, go to IDLE.
//   BRK: E0/F0 -> stay in BRK; b -> break{0,b}, go to IDLE.
//   EXT_BRK: E0/F0 -> stay in EXT_BRK; b -> break{1,b}, go to IDLE.
//   In EXT/BRK/EXT_BRK, PREFIX_TIMEOUT cycles with no byte -> IDLE with no event.
//  Lookup: the 9-bit code is compared against all KEYMAP entries; the lowest (p,a) match wins.
//  Unmapped codes (incl. AA, E1, FA) produce no event.
//  Latency: tick of the final byte at cycle T -> held/direction/pulses updated at T+1 (registered).
//  Make on a key whose held bit is already 1 (typematic) is ignored: no pulse, counter untouched.
//  Direction make (new key): set held bit; direction=a; move_valid pulse (if enable); repeat counter=0.
//  Direction held: counter increments each cycle. At REPEAT_CYCLES-1: move_valid pulse with the current direction, counter=0.
//  Direction break: clear held bit. If a==direction and other direction bits are still held:
//   direction = lowest held index (UP<DOWN<LEFT<RIGHT), counter=0, no pulse.
//   If no direction bits remain held: direction=4, counter=0, no pulse.
//   Break of a non-current direction key only clears its held bit.
//  Bomb make (new key): set held[4]; bomb pulse (if enable). Break clears held[4]. Bomb never changes direction.
//  Same-cycle new make and repeat expiry for one player: one pulse only, for the new key; counter=0.
//  enable=0: held/direction still update; move_valid and bomb are forced 0; repeat counters are held at 0.
//  start: pulse at T+1 of the first mapped make after reset, independent of enable; never again until rst.
//  Players are fully independent; each byte affects at most one player.
// TESTING
//  1. rst, send 1D -> cycle T+1: start=1, move_valid[0]=1, direction[0]=0, held[0]=5'b00001; start never repeats.
//  2. Hold W: bytes 1D,1D,1D (typematic) -> single pulse; pulses then every REPEAT_CYCLES (set 16 in bench); F0 1D -> direction[0]=4, pulses stop.
//  3. P1 arrow: E0 75 -> move_valid[1]=1, direction[1]=0; then E0 F0 75 -> held[1]=0, direction[1]=4; plain 75 (no E0) -> no event.
//  4. Press 1D then 23, release 23 (F0 23) -> direction[0] returns to 0 with no pulse; repeat resumes 16 cycles later.
//  5. enable=0, send 29 -> bomb=0, held[0][4]=1; enable=1, send 29 again -> still no pulse (typematic); F0 29 then 29 -> bomb[0]=1.
//  6. Send F0, wait PREFIX_TIMEOUT+1 cycles, send 1C -> treated as make: direction[0]=2 and pulse; rst asserted mid E0 F0 -> all outputs return to reset values.

Source files
------------

// File: rtl/ps2_keymap_decoder_if.sv
// rtl/ps2_keymap_decoder_if.sv - byte input and per-player game outputs of the PS/2 keymap decoder
interface ps2_keymap_decoder_if #(
  parameter int N_PLAYERS = 2
);
  logic [7:0]             rx_data;
  logic                   rx_done_tick;
  logic                   enable;
  logic [N_PLAYERS-1:0]   move_valid;
  logic [3*N_PLAYERS-1:0] direction;
  logic [N_PLAYERS-1:0]   bomb;
  logic [5*N_PLAYERS-1:0] held;
  logic                   start;

  modport master (
    output rx_data, rx_done_tick, enable,
    input  move_valid, direction, bomb, held, start
  );

  modport slave (
    input  rx_data, rx_done_tick, enable,
    output move_valid, direction, bomb, held, start
  );
endinterface

// File: rtl/ps2_keymap_decoder.sv
// rtl/ps2_keymap_decoder.sv - set-2 scan-code parser with per-player held keys, move repeat and bomb/start pulses
module ps2_keymap_decoder #(
  parameter int N_PLAYERS = 2,
  parameter logic [N_PLAYERS*45-1:0] KEYMAP = {
    9'h05A, 9'h174, 9'h16B, 9'h172, 9'h175,
    9'h029, 9'h023, 9'h01C, 9'h01B, 9'h01D
  },
  parameter int REPEAT_CYCLES  = 2_500_000,
  parameter int PREFIX_TIMEOUT = 50_000
) (
  input  logic clk,
  input  logic rst,
  ps2_keymap_decoder_if.slave bus
);
  localparam int CW = $clog2(REPEAT_CYCLES);
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);
  localparam logic [2:0]    DIR_STOP = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 ev_valid, ev_make;
  logic [8:0]           ev_code;
  logic                 hit;
  logic [PW-1:0]        hit_p;
  logic [2:0]           hit_a;
  logic [4:0]           held_q [N_PLAYERS];
  logic [4:0]           held_d [N_PLAYERS];
  logic [2:0]           dir_q  [N_PLAYERS];
  logic [2:0]           dir_d  [N_PLAYERS];
  logic [CW-1:0]        cnt_q  [N_PLAYERS];
  logic [CW-1:0]        cnt_d  [N_PLAYERS];
  logic [N_PLAYERS-1:0] move_q, move_d, bomb_q, bomb_d;
  logic                 start_q, start_d, started_q, started_d;
  logic                 is_e0, is_f0;

  assign is_e0 = (bus.rx_data == 8'hE0);
  assign is_f0 = (bus.rx_data == 8'hF0);

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    ev_valid = 1'b0;
    ev_make  = 1'b0;
    ev_code  = 9'd0;
    if (bus.rx_done_tick) begin
      tmo_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (is_e0)      state_d = S_EXT;
          else if (is_f0) state_d = S_BRK;
          else begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
            ev_code  = {1'b0, bus.rx_data};
          end
        end
        S_EXT: begin
          if (is_f0)      state_d = S_EXT_BRK;
          else if (is_e0) state_d = S_EXT;
          else begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
            ev_code  = {1'b1, bus.rx_data};
            state_d  = S_IDLE;
          end
        end
        S_BRK: begin
          if (!(is_e0 || is_f0)) begin
            ev_valid = 1'b1;
            ev_code  = {1'b0, bus.rx_data};
            state_d  = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (!(is_e0 || is_f0)) begin
            ev_valid = 1'b1;
            ev_code  = {1'b1, bus.rx_data};
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // A prefix whose follow-up byte never arrives is abandoned silently
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_comb begin
    hit   = 1'b0;
    hit_p = '0;
    hit_a = 3'd0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      for (int a = 0; a < 5; a++) begin
        if (ev_valid && !hit && KEYMAP[(p*5+a)*9 +: 9] == ev_code) begin
          hit   = 1'b1;
          hit_p = PW'(p);
          hit_a = 3'(a);
        end
      end
    end
  end

  always_comb begin
    start_d   = 1'b0;
    started_d = started_q;
    if (hit && ev_make && !started_q) begin
      start_d   = 1'b1;
      started_d = 1'b1;
    end
    for (int p = 0; p < N_PLAYERS; p++) begin
      held_d[p] = held_q[p];
      dir_d[p]  = dir_q[p];
      cnt_d[p]  = cnt_q[p];
      move_d[p] = 1'b0;
      bomb_d[p] = 1'b0;
      if (!bus.enable || dir_q[p] == DIR_STOP) begin
        cnt_d[p] = '0;
      end else if (cnt_q[p] == REP_LAST) begin
        cnt_d[p]  = '0;
        move_d[p] = 1'b1;
      end else begin
        cnt_d[p] = cnt_q[p] + 1'b1;
      end
      if (hit && hit_p == PW'(p)) begin
        if (ev_make) begin
          // Typematic repeats of an already-held key fall through untouched
          if (!held_q[p][hit_a]) begin
            held_d[p][hit_a] = 1'b1;
            if (hit_a == 3'd4) begin
              bomb_d[p] = bus.enable;
            end else begin
              dir_d[p]  = hit_a;
              move_d[p] = bus.enable;
              cnt_d[p]  = '0;
            end
          end
        end else begin
          held_d[p][hit_a] = 1'b0;
          if (hit_a != 3'd4 && hit_a == dir_q[p]) begin
            move_d[p] = 1'b0;
            cnt_d[p]  = '0;
            dir_d[p]  = DIR_STOP;
            for (int i = 3; i >= 0; i--) begin
              if (held_d[p][i]) dir_d[p] = 3'(i);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      move_q    <= '0;
      bomb_q    <= '0;
      start_q   <= 1'b0;
      started_q <= 1'b0;
      for (int p = 0; p < N_PLAYERS; p++) begin
        held_q[p] <= 5'd0;
        dir_q[p]  <= DIR_STOP;
        cnt_q[p]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      move_q    <= move_d;
      bomb_q    <= bomb_d;
      start_q   <= start_d;
      started_q <= started_d;
      for (int p = 0; p < N_PLAYERS; p++) begin
        held_q[p] <= held_d[p];
        dir_q[p]  <= dir_d[p];
        cnt_q[p]  <= cnt_d[p];
      end
    end
  end

  assign bus.move_valid = move_q;
  assign bus.bomb       = bomb_q;
  assign bus.start      = start_q;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_out
    assign bus.held[5*g +: 5]      = held_q[g];
    assign bus.direction[3*g +: 3] = dir_q[g];
  end
endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// tb/tb_ps2_keymap_decoder.sv - scoreboard bench for the PS/2 keymap decoder
module tb_ps2_keymap_decoder;
  localparam int REP   = 16;
  localparam int PTO   = 20;
  localparam int LIMIT = 5000;

  typedef struct {
    string      name;
    int         cyc;
    logic [1:0] mv;
    logic [1:0] bm;
    logic       st;
    logic [5:0] dir;
    logic [9:0] held;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_k = 0;
  int   k = 0;
  bit   done = 1'b0;
  rec_t pq[$];
  rec_t sq[$];

  ps2_keymap_decoder_if #(.N_PLAYERS(2)) bus ();

  ps2_keymap_decoder #(
    .N_PLAYERS(2),
    .REPEAT_CYCLES(REP),
    .PREFIX_TIMEOUT(PTO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic rec_t mk(string n, int c, logic [1:0] mv, logic [1:0] bm, logic st,
                              logic [5:0] dir, logic [9:0] held);
    rec_t r;
    r.name = n; r.cyc = c; r.mv = mv; r.bm = bm; r.st = st; r.dir = dir; r.held = held;
    return r;
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done_tick = 1'b1;
    last_k = cyc + 1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic send_exp(input logic [7:0] b, input string n, input logic [1:0] mv,
                          input logic [1:0] bm, input logic st, input logic [5:0] dir,
                          input logic [9:0] held);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done_tick = 1'b1;
    last_k = cyc + 1;
    pq.push_back(mk(n, last_k, mv, bm, st, dir, held));
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic probe(input string n, input logic [5:0] dir, input logic [9:0] held);
    sq.push_back(mk(n, cyc + 1, 2'b00, 2'b00, 1'b0, dir, held));
    @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic void compare(rec_t e);
    total++;
    if (e.cyc != cyc || bus.move_valid !== e.mv || bus.bomb !== e.bm || bus.start !== e.st ||
        bus.direction !== e.dir || bus.held !== e.held) begin
      bad++;
      $display("FAIL %s: got cyc=%0d mv=%b bomb=%b start=%b dir=%b held=%b, want cyc=%0d mv=%b bomb=%b start=%b dir=%b held=%b",
               e.name, cyc, bus.move_valid, bus.bomb, bus.start, bus.direction, bus.held,
               e.cyc, e.mv, e.bm, e.st, e.dir, e.held);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && (bus.move_valid != 2'b00 || bus.bomb != 2'b00 || bus.start)) begin
      if (pq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got cyc=%0d mv=%b bomb=%b start=%b dir=%b, want no pulse",
                 cyc, bus.move_valid, bus.bomb, bus.start, bus.direction);
      end else begin
        compare(pq.pop_front());
      end
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) compare(sq.pop_front());
    if (cyc > LIMIT) begin
      total++;
      bad++;
      $display("FAIL watchdog: got cyc=%0d, want done before %0d", cyc, LIMIT);
    end
    if (done || cyc > LIMIT) begin
      total++;
      if (pq.size() != 0 || sq.size() != 0) begin
        bad++;
        $display("FAIL leftover: got pending pulses=%0d probes=%0d, want 0 and 0", pq.size(), sq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    rst = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_done_tick = 1'b0;
    bus.enable = 1'b1;
    repeat (3) @(negedge clk);
    probe("reset", 6'b100_100, 10'h000);
    rst = 1'b0;

    send_exp(8'h1D, "t1_make", 2'b01, 2'b00, 1'b1, 6'b100_000, 10'h001);
    k = last_k;
    probe("t1_state", 6'b100_000, 10'h001);

    send(8'h1D); send(8'h1D); send(8'h1D);
    pq.push_back(mk("t2_rep1", k + REP, 2'b01, 2'b00, 1'b0, 6'b100_000, 10'h001));
    pq.push_back(mk("t2_rep2", k + 2*REP, 2'b01, 2'b00, 1'b0, 6'b100_000, 10'h001));
    wait_until(k + 2*REP + 1);
    send(8'hF0); send(8'h1D);
    probe("t2_release", 6'b100_100, 10'h000);
    repeat (3*REP) @(negedge clk);

    send(8'hE0);
    send_exp(8'h75, "t3_make", 2'b10, 2'b00, 1'b0, 6'b000_100, 10'b00001_00000);
    probe("t3_state", 6'b000_100, 10'b00001_00000);
    send(8'hE0); send(8'hF0); send(8'h75);
    probe("t3_break", 6'b100_100, 10'h000);
    send(8'h75);
    probe("t3_plain", 6'b100_100, 10'h000);

    send_exp(8'h1D, "t4_w", 2'b01, 2'b00, 1'b0, 6'b100_000, 10'h001);
    send_exp(8'h23, "t4_d", 2'b01, 2'b00, 1'b0, 6'b100_011, 10'h009);
    send(8'hF0); send(8'h23);
    k = last_k;
    probe("t4_back", 6'b100_000, 10'h001);
    pq.push_back(mk("t4_resume", k + REP, 2'b01, 2'b00, 1'b0, 6'b100_000, 10'h001));
    wait_until(k + REP + 1);
    send(8'hF0); send(8'h1D);
    probe("t4_release", 6'b100_100, 10'h000);

    bus.enable = 1'b0;
    send(8'h29);
    probe("t5_bomb_dis", 6'b100_100, 10'h010);
    send(8'h1B);
    probe("t5_move_dis", 6'b100_001, 10'h012);
    repeat (2*REP) @(negedge clk);
    send(8'hF0); send(8'h1B);
    probe("t5_rel_dis", 6'b100_100, 10'h010);
    bus.enable = 1'b1;
    send(8'h29);
    probe("t5_typematic", 6'b100_100, 10'h010);
    send(8'hF0); send(8'h29);
    probe("t5_bomb_rel", 6'b100_100, 10'h000);
    send_exp(8'h29, "t5_bomb", 2'b00, 2'b01, 1'b0, 6'b100_100, 10'h010);
    send(8'hF0); send(8'h29);

    send(8'hF0);
    repeat (PTO + 1) @(negedge clk);
    send_exp(8'h1C, "t6_timeout", 2'b01, 2'b00, 1'b0, 6'b100_010, 10'h004);
    send(8'hE0); send(8'hF0);
    rst = 1'b1;
    probe("t6_reset", 6'b100_100, 10'h000);
    rst = 1'b0;
    send_exp(8'h1D, "t6_restart", 2'b01, 2'b00, 1'b1, 6'b100_000, 10'h001);
    probe("t6_state", 6'b100_000, 10'h001);
    repeat (2) @(negedge clk);
    done = 1'b1;
  end
endmodule
